// File: rtl/block_obstacle.sv
`default_nettype none
// ============================================================================
//  Module      : block_obstacle
//  Description : Solid rectangular obstacle that scrolls left by STEP pixels
//                per screen update. On each draw request it streams its pixels
//                in raster order to the shape controller. When a move is
//                pending, it first erases the block at the old position and
//                then draws it at the new one.
//                Optional macro: BLOCK_OBSTACLE_ERASE_EN compiles in the
//                erase pass. Without it, the move is applied at the start of
//                the pass and only the draw pass runs.
//  Revision    : 1.0 - initial release
// ============================================================================
module block_obstacle #(
   parameter int          SCREEN_W = 160,
   parameter int          BLOCK_W  = 10,
   parameter int          BLOCK_H  = 10,
   parameter int          X_START  = 150,
   parameter int          Y_POS    = 100,
   parameter int          STEP     = 2,
   parameter logic [2:0]  COLOUR   = 3'b010
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        draw_start,
   input  logic        update_screen,
   output logic [10:0] x_out,
   output logic [10:0] y_out,
   output logic [2:0]  colour_out,
   output logic        draw_done
);

   localparam logic [10:0] CX_LAST = 11'(BLOCK_W - 1);
   localparam logic [10:0] CY_LAST = 11'(BLOCK_H - 1);
   localparam logic [10:0] STEP_V  = 11'(STEP);
   localparam logic [10:0] WRAP_X  = 11'(SCREEN_W - BLOCK_W);
   localparam logic [10:0] X_INIT  = 11'(X_START);
   localparam logic [10:0] Y_BASE  = 11'(Y_POS);

`ifdef BLOCK_OBSTACLE_ERASE_EN
   typedef enum logic [1:0] {IDLE = 2'd0, ERASE = 2'd1, DRAW = 2'd2, DONE = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, DRAW = 2'd2, DONE = 2'd3} state_t;
`endif

   state_t      state, state_nxt;
   logic [10:0] x_pos, x_pos_nxt;
   logic        move_pending, pending_nxt;
   logic [10:0] cx, cx_nxt, cy, cy_nxt;
   logic [10:0] x_out_nxt, y_out_nxt;
   logic [2:0]  colour_nxt;
   logic [10:0] x_moved;
   logic [10:0] step_cx, step_cy;
   logic        last_pix;

   // Position after one move, wrapping to the right edge when it would go negative
   assign x_moved  = (x_pos >= STEP_V) ? (x_pos - STEP_V) : WRAP_X;
   // cx/cy always name the pixel currently on the outputs
   assign last_pix = (cx == CX_LAST) && (cy == CY_LAST);
   assign draw_done = (state == DONE);

   // Next-state, next pixel and move bookkeeping
   always_comb begin
      state_nxt   = state;
      x_pos_nxt   = x_pos;
      cx_nxt      = cx;
      cy_nxt      = cy;
      x_out_nxt   = x_out;
      y_out_nxt   = y_out;
      colour_nxt  = colour_out;
      pending_nxt = move_pending | update_screen;
      if (cx == CX_LAST) begin
         step_cx = 11'd0;
         step_cy = cy + 11'd1;
      end else begin
         step_cx = cx + 11'd1;
         step_cy = cy;
      end

      case (state)
         IDLE: begin
            if (draw_start) begin
               cx_nxt    = 11'd0;
               cy_nxt    = 11'd0;
               y_out_nxt = Y_BASE;
`ifdef BLOCK_OBSTACLE_ERASE_EN
               x_out_nxt = x_pos;
               if (move_pending) begin
                  state_nxt  = ERASE;
                  colour_nxt = 3'b000;
               end else begin
                  state_nxt  = DRAW;
                  colour_nxt = COLOUR;
               end
`else
               state_nxt  = DRAW;
               colour_nxt = COLOUR;
               if (move_pending) begin
                  x_pos_nxt   = x_moved;
                  x_out_nxt   = x_moved;
                  pending_nxt = update_screen;
               end else begin
                  x_out_nxt = x_pos;
               end
`endif
            end
         end
`ifdef BLOCK_OBSTACLE_ERASE_EN
         ERASE: begin
            if (last_pix) begin
               // Move lands on the same edge that presents the first draw pixel
               state_nxt   = DRAW;
               x_pos_nxt   = x_moved;
               pending_nxt = update_screen;
               cx_nxt      = 11'd0;
               cy_nxt      = 11'd0;
               x_out_nxt   = x_moved;
               y_out_nxt   = Y_BASE;
               colour_nxt  = COLOUR;
            end else begin
               cx_nxt    = step_cx;
               cy_nxt    = step_cy;
               x_out_nxt = x_pos + step_cx;
               y_out_nxt = Y_BASE + step_cy;
            end
         end
`endif
         DRAW: begin
            if (last_pix) begin
               state_nxt = DONE;
            end else begin
               cx_nxt    = step_cx;
               cy_nxt    = step_cy;
               x_out_nxt = x_pos + step_cx;
               y_out_nxt = Y_BASE + step_cy;
            end
         end
         DONE: begin
            if (!draw_start) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, position, counters and registered pixel outputs
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state        <= IDLE;
         x_pos        <= X_INIT;
         move_pending <= 1'b0;
         cx           <= 11'd0;
         cy           <= 11'd0;
         x_out        <= X_INIT;
         y_out        <= Y_BASE;
         colour_out   <= 3'b000;
      end else begin
         state        <= state_nxt;
         x_pos        <= x_pos_nxt;
         move_pending <= pending_nxt;
         cx           <= cx_nxt;
         cy           <= cy_nxt;
         x_out        <= x_out_nxt;
         y_out        <= y_out_nxt;
         colour_out   <= colour_nxt;
      end
   end

endmodule
`default_nettype wire

// File: doc/block_obstacle.md
BLOCK_OBSTACLE -- requirements
Module: block_obstacle

Interface
REQ-001 The block SHALL have parameter SCREEN_W, default 160: visible screen width in pixels.
REQ-002 The block SHALL have parameter BLOCK_W, default 10: block width in pixels.
REQ-003 The block SHALL have parameter BLOCK_H, default 10: block height in pixels.
REQ-004 The block SHALL have parameter X_START, default 150: block left x after reset.
REQ-005 The block SHALL have parameter Y_POS, default 100: fixed block top y.
REQ-006 The block SHALL have parameter STEP, default 2: pixels moved left per screen update.
REQ-007 The block SHALL have parameter COLOUR, default 3'b010: block draw colour.
REQ-008 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-009 The block SHALL have port resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-010 The block SHALL have port draw_start, input, 1 bit: level request from the shape controller, held high until draw_done is seen.
REQ-011 The block SHALL have port update_screen, input, 1 bit: one-cycle frame-tick pulse requesting a move.
REQ-012 The block SHALL have port x_out, output, 11 bits: pixel x presented to the controller mux.
REQ-013 The block SHALL have port y_out, output, 11 bits: pixel y.
REQ-014 The block SHALL have port colour_out, output, 3 bits: pixel colour.
REQ-015 The block SHALL have port draw_done, output, 1 bit: pass-complete handshake.

Function
REQ-016 The block SHALL implement an FSM with states IDLE, ERASE, DRAW and DONE, and SHALL hold an 11-bit x_pos register, a move_pending flag, and pixel counters cx (0..BLOCK_W-1) and cy (0..BLOCK_H-1).
REQ-017 The block SHALL advance cx fastest, and SHALL advance cy when cx wraps (raster order).
REQ-018 The block SHALL set move_pending on any cycle that update_screen is high, in any state; repeated pulses before the move is applied SHALL coalesce into a single step.
REQ-019 In IDLE with draw_start high, the block SHALL enter ERASE if move_pending is set, and DRAW otherwise, with cx=cy=0.
REQ-020 The block SHALL present pixel n of a pass (n=0..BLOCK_W*BLOCK_H-1) on the registered outputs in the (n+1)th cycle after the sampling edge.
REQ-021 The block SHALL drive x_out = x_pos+cx and y_out = Y_POS+cy.
REQ-022 The block SHALL drive colour_out = 3'b000 in ERASE and COLOUR in DRAW.
REQ-023 At the last ERASE pixel, the block SHALL apply the move, clear move_pending, and enter DRAW with no bubble cycle.
REQ-024 The move SHALL set x_pos to x_pos-STEP if x_pos >= STEP, and to SCREEN_W-BLOCK_W otherwise (wrap-around).
REQ-025 After the last DRAW pixel, the block SHALL enter DONE, and draw_done SHALL be high in DONE only.
REQ-026 In DONE, the block SHALL return to IDLE at the first edge where draw_start is sampled low.
REQ-027 Deassertion of draw_start during ERASE or DRAW SHALL be ignored; the pass SHALL complete.
REQ-028 In IDLE and DONE, outputs SHALL hold the last presented pixel.
REQ-029 Parameters SHALL satisfy X_START+BLOCK_W <= SCREEN_W and STEP < SCREEN_W; with these, 11-bit arithmetic SHALL NOT overflow.
REQ-030 With defaults, a pass SHALL last 100 cycles (DRAW only) or 200 cycles (ERASE+DRAW) before draw_done rises.

Reset
REQ-031 While resetn is low, the block SHALL immediately set: state IDLE, x_pos=X_START, move_pending=0, cx=cy=0, x_out=X_START, y_out=Y_POS, colour_out=3'b000, draw_done=0.
REQ-032 Reset asserted mid-pass SHALL abort the pass with no further pixels; the next pass SHALL start from X_START with no erase.

Configuration
REQ-033 With macro BLOCK_OBSTACLE_ERASE_EN defined, the ERASE state and REQ-019/REQ-023 erase behaviour SHALL be compiled in.
REQ-034 Without BLOCK_OBSTACLE_ERASE_EN, ERASE SHALL be absent; in IDLE with draw_start high and move_pending set, the block SHALL apply the move and clear move_pending at the sampling edge, then enter DRAW.

Verification
REQ-035 Release reset, then hold draw_start -> pixels (150,100)..(159,109) in colour 010; draw_done high at cycle 101; draw_done low one cycle after draw_start drops.
REQ-036 With ERASE_EN, pulse update_screen, then draw_start -> 100 pixels colour 000 at x 150..159, then 100 pixels colour 010 at x 148..157; draw_done at cycle 201.
REQ-037 After 75 update+draw cycles (x_pos=0), one more update -> next drawn pass at x 150..159 (wrap).
REQ-038 Two update_screen pulses during one DRAW pass -> next pass moves exactly 2 pixels, not 4.
REQ-039 resetn low at pixel 40 of DRAW -> draw_done=0 and outputs at reset values at once; next draw_start draws at x=150 with no erase.
REQ-040 Without ERASE_EN, pulse update_screen, then draw_start -> 100 pixels colour 010 at x 148..157 only; draw_done at cycle 101.
